fifo_pkt_reader: RTL and testbench
==================================

# fifo_pkt_reader

Drains a first-word-fallthrough packet FIFO and replays its contents onto a NetFPGA-style output bus with `out_data`, `out_ctrl`, `out_wr` and `out_rdy`. It sits at the read end of a small FWFT FIFO in output-queue and arbiter stages. It enforces packet framing and honours downstream back-pressure. Its enable takes effect only at packet boundaries, so packets are never truncated.

## Interface
- `DATA_WIDTH`, 64: width of the data lane.
- `CTRL_WIDTH`, `DATA_WIDTH/8`: width of the control lane.
- `HDR_CTRL`, 8'hFF: ctrl value that marks the first module-header word of a packet.
- `clk` input 1: the single clock. Reset is synchronous and active-high.
- `reset` input 1: synchronous, active-high reset.
- `fifo_dout` input `CTRL_WIDTH+DATA_WIDTH`: FIFO head word, formatted `{ctrl, data}`. Valid whenever `!fifo_empty`.
- `fifo_empty` input 1: FIFO has no word.
- `fifo_rd_en` output 1: pops the FIFO head. Combinational.
- `out_data` output `DATA_WIDTH`: registered data.
- `out_ctrl` output `CTRL_WIDTH`: registered ctrl.
- `out_wr` output 1: registered; the word on the bus is valid this cycle.
- `out_rdy` input 1: downstream can accept words.
- `enable` input 1: permits a new packet to start.
- `pkt_done` output 1: one-cycle pulse, coincident with `out_wr` of the EOP word.
- `framing_err` output 1: one-cycle pulse when a stray word is dropped.
- `pkt_cnt` output 32: count of packets sent. Wraps modulo 2^32.

## Operation
- **Head fields.** `hctrl = fifo_dout[DATA_WIDTH +: CTRL_WIDTH]`. `avail = !fifo_empty`.
- **State IDLE** (between packets):
  - `avail && enable && hctrl==HDR_CTRL && out_rdy`: pop and forward the word, go to HDR.
  - `avail && enable && hctrl!=HDR_CTRL`: pop and drop the word, pulse `framing_err` on the next cycle, stay in IDLE. A drop does not require `out_rdy`.
  - `!enable`: no pop.
- **State HDR** (module headers, ctrl≠0):
  - `avail && out_rdy`: pop and forward.
  - Forwarded word with `hctrl==0`: go to PAYLOAD.
  - Forwarded word with `hctrl!=0`: stay in HDR.
- **State PAYLOAD:**
  - `avail && out_rdy`: pop and forward.
  - Forwarded word with `hctrl!=0` is EOP. Go to IDLE, assert `pkt_done` with that word, increment `pkt_cnt`.
- **Enable.** `enable` is sampled only in IDLE. Deasserting it in HDR or PAYLOAD lets the current packet finish.
- **Pop rule.** `fifo_rd_en` is asserted only when `avail`. The block never reads an empty FIFO.
- **Reset.** State goes to IDLE. `out_wr`, `out_data`, `out_ctrl`, `pkt_done`, `framing_err` and `pkt_cnt` all go to 0. A partial packet in flight is abandoned. The FIFO is reset by its owner.

## Timing
- **Latency.** A pop in cycle N produces `out_wr=1` in cycle N+1, carrying the popped word.
- **Throughput.** One word per cycle while `avail && out_rdy`.
- **Back-pressure.** `out_rdy` is sampled in the pop cycle. Downstream must therefore tolerate one word arriving the cycle after it deasserts `out_rdy`. Downstream derives `out_rdy` from its FIFO's nearly-full flag.
- **Idle cycles.**
  - `out_wr=0` in any cycle that follows a non-pop cycle or a drop cycle.
  - `out_data` and `out_ctrl` hold their last value when `out_wr=0`.
- **Stalls.** `fifo_empty` rising mid-packet stalls the block in its current state with no output. Forwarding resumes when a word arrives.
- **Single-word packet.** A header with ctrl=FF followed directly by a nonzero ctrl word stays in HDR. Only a ctrl=0 word enters PAYLOAD.
- **Counter wrap.** `pkt_cnt` at FFFF_FFFF plus one EOP gives 0, with no flag.

## Structure
- Shared defines file holds:
  - `DATA_WIDTH`, `CTRL_WIDTH`, `HDR_CTRL` (IO_QUEUE_STAGE_NUM);
  - the state encodings IDLE=0, HDR=1, PAYLOAD=2.
- Single module; no sub-module. The FWFT FIFO is instantiated by the parent.

## Test plan
- **Basic packet.** FIFO holds FF/hdr, 00/d0, 00/d1, 40/d2, with `out_rdy=1` and `enable=1`.
  - Required: four consecutive `out_wr` cycles starting one cycle after the first pop.
  - `pkt_done` is asserted with the 40/d2 word, and `pkt_cnt` becomes 1.
- **Back-pressure.** Toggle `out_rdy` 1,0,0,1 during the payload.
  - Required: no pop while `out_rdy=0`.
  - Words are forwarded in order with none lost or duplicated.
  - Exactly one word appears the cycle after `out_rdy` falls.
- **Enable boundary.** Drop `enable` in the middle of the payload of packet 1, with packet 2 queued behind it.
  - Required: packet 1 completes.
  - Packet 2 is not popped until `enable` returns to 1.
- **Framing error.** In IDLE, head word is 00/dead.
  - Required: the word is popped with `out_rdy=0` and never appears on the bus.
  - `framing_err` pulses once.
  - A following FF packet is then forwarded normally.
- **Reset and empty.**
  - Assert `reset` in PAYLOAD. Required: all outputs are 0 on the next cycle and the state is IDLE.
  - Keep `fifo_empty=1` throughout. Required: `fifo_rd_en` is never asserted.

Source files
------------

// File: rtl/fifo_pkt_reader_pkg.sv
// Shared widths, header marker and FSM encoding for the FWFT packet reader.
package fifo_pkt_reader_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned CTRL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned WORD_WIDTH = CTRL_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_WIDTH  = 32;

  localparam logic [CTRL_WIDTH-1:0] HDR_CTRL = CTRL_WIDTH'(8'hFF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_pkt_reader_if.sv
// NetFPGA-style output bus: registered data/ctrl/wr forward, rdy back-pressure.
interface fifo_pkt_reader_if;
  import fifo_pkt_reader_pkg::*;

  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;

  modport master (output out_data, output out_ctrl, output out_wr, input out_rdy);
  modport slave  (input out_data, input out_ctrl, input out_wr, output out_rdy);
endinterface

// File: rtl/fifo_pkt_reader.sv
// Drains an FWFT packet FIFO onto the output bus, keeping packet framing and
// only starting new packets while enable is high.
module fifo_pkt_reader
  import fifo_pkt_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  enable,
  output logic                  pkt_done,
  output logic                  framing_err,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  fifo_pkt_reader_if.master     out_bus
);

  state_t                state;
  logic [CTRL_WIDTH-1:0] hctrl_c;
  logic                  avail_c;
  logic                  fwd_c;
  logic                  drop_c;

  assign hctrl_c = fifo_dout[DATA_WIDTH +: CTRL_WIDTH];
  assign avail_c = !fifo_empty;

  // Pop decision: forward needs downstream room, a stray-word drop does not.
  always_comb begin
    fwd_c  = 1'b0;
    drop_c = 1'b0;
    if (!reset && avail_c) begin
      case (state)
        IDLE: begin
          if (enable) begin
            if (hctrl_c == HDR_CTRL) fwd_c  = out_bus.out_rdy;
            else                     drop_c = 1'b1;
          end
        end
        HDR, PAYLOAD: fwd_c = out_bus.out_rdy;
        default: fwd_c = 1'b0;
      endcase
    end
  end

  assign fifo_rd_en = fwd_c | drop_c;

  // Framing FSM with registered bus and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      out_bus.out_wr   <= 1'b0;
      out_bus.out_data <= '0;
      out_bus.out_ctrl <= '0;
      pkt_done         <= 1'b0;
      framing_err      <= 1'b0;
      pkt_cnt          <= '0;
    end else begin
      out_bus.out_wr <= fwd_c;
      framing_err    <= drop_c;
      pkt_done       <= 1'b0;
      if (fwd_c) begin
        out_bus.out_data <= fifo_dout[DATA_WIDTH-1:0];
        out_bus.out_ctrl <= hctrl_c;
        case (state)
          IDLE: state <= HDR;
          HDR: begin
            if (hctrl_c == '0) state <= PAYLOAD;
          end
          PAYLOAD: begin
            if (hctrl_c != '0) begin
              state    <= IDLE;
              pkt_done <= 1'b1;
              pkt_cnt  <= pkt_cnt + CNT_WIDTH'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader with a small array-based FWFT FIFO model.
module tb_fifo_pkt_reader;
  import fifo_pkt_reader_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  enable;
  logic [WORD_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic                  pkt_done;
  logic                  framing_err;
  logic [31:0]           pkt_cnt;

  fifo_pkt_reader_if bus ();

  fifo_pkt_reader dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .enable      (enable),
    .pkt_done    (pkt_done),
    .framing_err (framing_err),
    .pkt_cnt     (pkt_cnt),
    .out_bus     (bus.master)
  );

  always #5 clk = ~clk;

  logic [WORD_WIDTH-1:0] mem [0:255];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int bad_pop = 0;
  bit force_empty = 1'b0;

  assign fifo_dout  = mem[rd_ptr];
  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_ptr <= rd_ptr + 1;
      if (fifo_empty) bad_pop <= bad_pop + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [WORD_WIDTH-1:0] cap [$];
  int done_cnt;
  int ferr_cnt;

  task automatic push(input logic [7:0] c, input logic [63:0] d);
    mem[wr_ptr] = {c, d};
    wr_ptr++;
  endtask

  // Advance one cycle and log what the bus shows just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.out_wr === 1'b1) cap.push_back({bus.out_ctrl, bus.out_data});
    if (pkt_done === 1'b1) done_cnt++;
    if (framing_err === 1'b1) ferr_cnt++;
  endtask

  task automatic clear_log();
    cap.delete();
    done_cnt = 0;
    ferr_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; bus.out_rdy = 1'b0;
    tick(); tick();
    checks++; if (bus.out_wr !== 1'b0) begin errors++; $display("FAIL reset_out_wr: got %b want 0", bus.out_wr); end
    checks++; if (bus.out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    checks++; if (bus.out_ctrl !== 8'h0) begin errors++; $display("FAIL reset_out_ctrl: got %h want 0", bus.out_ctrl); end
    checks++; if (pkt_done !== 1'b0 || framing_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%b ferr=%b want 0,0", pkt_done, framing_err); end
    checks++; if (pkt_cnt !== 32'h0) begin errors++; $display("FAIL reset_pkt_cnt: got %h want 0", pkt_cnt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [WORD_WIDTH-1:0] exp [4];
    exp[0] = {8'hFF, 64'h0000_0000_0000_1111};
    exp[1] = {8'h00, 64'h0000_0000_0000_00D0};
    exp[2] = {8'h00, 64'h0000_0000_0000_00D1};
    exp[3] = {8'h40, 64'h0000_0000_0000_00D2};
    clear_log();
    for (int i = 0; i < 4; i++) push(exp[i][71:64], exp[i][63:0]);
    bus.out_rdy = 1'b1; enable = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL basic_first_pop: got %b want 1", fifo_rd_en); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.out_wr !== 1'b1 || {bus.out_ctrl, bus.out_data} !== exp[i]) begin
        errors++; $display("FAIL basic_word%0d: got wr=%b %h want wr=1 %h", i, bus.out_wr, {bus.out_ctrl, bus.out_data}, exp[i]);
      end
      checks++; if (pkt_done !== (i == 3)) begin errors++; $display("FAIL basic_done%0d: got %b want %b", i, pkt_done, (i == 3)); end
    end
    checks++; if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL basic_pkt_cnt: got %0d want 1", pkt_cnt); end
    tick();
    checks++; if (bus.out_wr !== 1'b0 || bus.out_data !== 64'hD2 || bus.out_ctrl !== 8'h40) begin
      errors++; $display("FAIL basic_idle_hold: got wr=%b %h/%h want wr=0 40/d2", bus.out_wr, bus.out_ctrl, bus.out_data);
    end
  endtask

  task automatic test_backpressure();
    logic [WORD_WIDTH-1:0] exp [5];
    exp[0] = {8'hFF, 64'h2000}; exp[1] = {8'h00, 64'h2001}; exp[2] = {8'h00, 64'h2002};
    exp[3] = {8'h00, 64'h2003}; exp[4] = {8'h20, 64'h2004};
    clear_log();
    for (int i = 0; i < 5; i++) push(exp[i][71:64], exp[i][63:0]);
    for (int c = 0; c < 10; c++) begin
      bus.out_rdy = !(c == 2 || c == 3);
      #1;
      if (c == 2 || c == 3) begin
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_no_pop_c%0d: got %b want 0", c, fifo_rd_en); end
      end
      if (c == 2) begin
        checks++; if (bus.out_wr !== 1'b1 || bus.out_data !== 64'h2001) begin
          errors++; $display("FAIL bp_inflight: got wr=%b %h want wr=1 2001", bus.out_wr, bus.out_data);
        end
      end
      if (c == 3) begin
        checks++; if (bus.out_wr !== 1'b0) begin errors++; $display("FAIL bp_stall: got wr=%b want 0", bus.out_wr); end
      end
      tick();
    end
    checks++; if (cap.size() != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", cap.size()); end
    for (int i = 0; i < 5 && i < cap.size(); i++) begin
      checks++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL bp_order%0d: got %h want %h", i, cap[i], exp[i]); end
    end
    checks++; if (pkt_cnt !== 32'd2 || done_cnt != 1) begin errors++; $display("FAIL bp_done: got cnt=%0d pulses=%0d want 2,1", pkt_cnt, done_cnt); end
  endtask

  task automatic test_enable_boundary();
    logic [WORD_WIDTH-1:0] exp [8];
    exp[0] = {8'hFF, 64'h3000}; exp[1] = {8'h00, 64'h3001}; exp[2] = {8'h00, 64'h3002};
    exp[3] = {8'h00, 64'h3003}; exp[4] = {8'h80, 64'h3004};
    exp[5] = {8'hFF, 64'h4000}; exp[6] = {8'h00, 64'h4001}; exp[7] = {8'h01, 64'h4002};
    clear_log();
    for (int i = 0; i < 8; i++) push(exp[i][71:64], exp[i][63:0]);
    bus.out_rdy = 1'b1;
    for (int c = 0; c < 15; c++) begin
      enable = !(c >= 2 && c <= 8);
      #1;
      if (c >= 5 && c <= 8) begin
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL en_hold_c%0d: got %b want 0", c, fifo_rd_en); end
      end
      if (c == 8) begin
        checks++; if (pkt_cnt !== 32'd3) begin errors++; $display("FAIL en_pkt1_done: got %0d want 3", pkt_cnt); end
      end
      if (c == 9) begin
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL en_resume: got %b want 1", fifo_rd_en); end
      end
      tick();
    end
    checks++; if (cap.size() != 8) begin errors++; $display("FAIL en_count: got %0d want 8", cap.size()); end
    for (int i = 0; i < 8 && i < cap.size(); i++) begin
      checks++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL en_order%0d: got %h want %h", i, cap[i], exp[i]); end
    end
    checks++; if (pkt_cnt !== 32'd4 || done_cnt != 2) begin errors++; $display("FAIL en_done: got cnt=%0d pulses=%0d want 4,2", pkt_cnt, done_cnt); end
  endtask

  task automatic test_single_word_hdr();
    clear_log();
    push(8'hFF, 64'h5000); push(8'h05, 64'h5001); push(8'h00, 64'h5002); push(8'h02, 64'h5003);
    bus.out_rdy = 1'b1; enable = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      if (c == 2) begin
        checks++; if (bus.out_ctrl !== 8'h05 || pkt_done !== 1'b0) begin
          errors++; $display("FAIL hdr_nonzero: got ctrl=%h done=%b want 05,0", bus.out_ctrl, pkt_done);
        end
      end
      if (c == 4) begin
        checks++; if (bus.out_ctrl !== 8'h02 || pkt_done !== 1'b1) begin
          errors++; $display("FAIL hdr_eop: got ctrl=%h done=%b want 02,1", bus.out_ctrl, pkt_done);
        end
      end
      tick();
    end
    checks++; if (pkt_cnt !== 32'd5 || done_cnt != 1 || cap.size() != 4) begin
      errors++; $display("FAIL hdr_summary: got cnt=%0d pulses=%0d words=%0d want 5,1,4", pkt_cnt, done_cnt, cap.size());
    end
  endtask

  task automatic test_framing();
    logic [WORD_WIDTH-1:0] exp [3];
    exp[0] = {8'hFF, 64'h6000}; exp[1] = {8'h00, 64'h6001}; exp[2] = {8'h44, 64'h6002};
    clear_log();
    push(8'h00, 64'hDEAD);
    for (int i = 0; i < 3; i++) push(exp[i][71:64], exp[i][63:0]);
    bus.out_rdy = 1'b0; enable = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL ferr_drop_pop: got %b want 1", fifo_rd_en); end
    tick();
    checks++; if (framing_err !== 1'b1 || bus.out_wr !== 1'b0) begin
      errors++; $display("FAIL ferr_pulse: got ferr=%b wr=%b want 1,0", framing_err, bus.out_wr);
    end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL ferr_hdr_wait: got %b want 0", fifo_rd_en); end
    tick();
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL ferr_one_shot: got %b want 0", framing_err); end
    bus.out_rdy = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    checks++; if (cap.size() != 3) begin errors++; $display("FAIL ferr_count: got %0d want 3", cap.size()); end
    for (int i = 0; i < 3 && i < cap.size(); i++) begin
      checks++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL ferr_order%0d: got %h want %h", i, cap[i], exp[i]); end
    end
    checks++; if (ferr_cnt != 1 || pkt_cnt !== 32'd6) begin errors++; $display("FAIL ferr_summary: got pulses=%0d cnt=%0d want 1,6", ferr_cnt, pkt_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    clear_log();
    push(8'hFF, 64'h7000); push(8'h00, 64'h7001); push(8'h00, 64'h7002);
    push(8'h00, 64'h7003); push(8'h07, 64'h7004);
    bus.out_rdy = 1'b1; enable = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_no_pop: got %b want 0", fifo_rd_en); end
    tick();
    checks++; if (bus.out_wr !== 1'b0 || bus.out_data !== 64'h0 || bus.out_ctrl !== 8'h0) begin
      errors++; $display("FAIL rst_bus: got wr=%b %h/%h want 0 00/0", bus.out_wr, bus.out_ctrl, bus.out_data);
    end
    checks++; if (pkt_done !== 1'b0 || framing_err !== 1'b0 || pkt_cnt !== 32'h0) begin
      errors++; $display("FAIL rst_status: got done=%b ferr=%b cnt=%0d want 0,0,0", pkt_done, framing_err, pkt_cnt);
    end
    reset = 1'b0;
    #1;
    // Back in IDLE, the leftover payload word is a stray and gets dropped.
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL rst_idle_drop: got %b want 1", fifo_rd_en); end
    tick();
    checks++; if (framing_err !== 1'b1 || bus.out_wr !== 1'b0) begin
      errors++; $display("FAIL rst_idle_ferr: got ferr=%b wr=%b want 1,0", framing_err, bus.out_wr);
    end
    tick(); tick();
    checks++; if (fifo_empty !== 1'b1 || ferr_cnt != 2) begin
      errors++; $display("FAIL rst_drain: got empty=%b pulses=%0d want 1,2", fifo_empty, ferr_cnt);
    end
  endtask

  task automatic test_empty();
    int wr_seen;
    wr_seen = 0;
    force_empty = 1'b1; enable = 1'b1; bus.out_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (fifo_rd_en !== 1'b0) wr_seen++;
      tick();
      if (bus.out_wr !== 1'b0) wr_seen++;
    end
    checks++; if (wr_seen != 0) begin errors++; $display("FAIL empty_idle: got %0d events want 0", wr_seen); end
    checks++; if (bad_pop != 0) begin errors++; $display("FAIL empty_pop: got %0d want 0", bad_pop); end
    force_empty = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_enable_boundary();
    test_single_word_hdr();
    test_framing();
    test_reset_mid_packet();
    test_empty();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
